// File: rtl/ram_bus_pkg.sv
// Shared constants for the 4-bit multiplexed RAM bus: frame cycle numbers,
// RAM I/O opcodes, request kinds and the master's state encoding.
package ram_bus_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    localparam logic [2:0] CYC_OPC    = 3'd4;
    localparam logic [2:0] CYC_SRC_HI = 3'd6;
    localparam logic [2:0] CYC_SRC_LO = 3'd7;
    localparam logic [2:0] CYC_IO     = 3'd6;

    localparam logic [3:0] OP_WRM = 4'h0;
    localparam logic [3:0] OP_SBM = 4'h8;
    localparam logic [3:0] OP_RDM = 4'h9;
    localparam logic [3:0] OP_ADM = 4'hB;

    typedef enum logic {
        KIND_SRC = 1'b0,
        KIND_IO  = 1'b1
    } req_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    // Opcodes whose cycle-6 nibble is driven by the RAM and captured here.
    function automatic logic is_read_op(input logic [3:0] op);
        return (op == OP_SBM) || (op == OP_RDM) || (op == OP_ADM);
    endfunction

endpackage

// File: rtl/bus_cycle_counter.sv
// Free-running 3-bit bus cycle counter; every agent on the bus instantiates
// the same counter so all of them stay in lockstep after a common reset.
module bus_cycle_counter
    import ram_bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] cycle
);

    logic [2:0] cycle_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= CYC_A1;
        end else begin
            cycle_q <= cycle_q + 3'd1;
        end
    end

    assign cycle = cycle_q;

endmodule

// File: rtl/ram_bus_master.sv
// CPU-side initiator for the multiplexed RAM bus: turns one core request
// (SRC select or RAM I/O instruction) into one 8-cycle bus frame.
module ram_bus_master
    import ram_bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    inout  wire  [3:0] data,
    output logic       sync,
    output logic       cmd_n,
    output logic [2:0] cycle,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_kind,
    input  logic [7:0] req_addr,
    input  logic [3:0] req_opcode,
    input  logic [3:0] req_wdata,
    output logic       rsp_valid,
    output logic [3:0] rsp_rdata
);

    state_e     state_q;
    req_kind_e  kind_q;
    logic [7:0] addr_q;
    logic [3:0] opc_q;
    logic [3:0] wdata_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_rdata_q;

    logic       accept;
    logic       drv_en;
    logic [3:0] drv_val;
    logic       cmd_n_d;

    bus_cycle_counter u_counter (
        .clock (clock),
        .reset (reset),
        .cycle (cycle)
    );

    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_BUSY && cycle == CYC_X3);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_SRC;
            addr_q      <= 8'h00;
            opc_q       <= 4'h0;
            wdata_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 4'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                kind_q  <= req_kind_e'(req_kind);
                addr_q  <= req_addr;
                opc_q   <= req_opcode;
                wdata_q <= req_wdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= (cycle == CYC_X3) ? ST_BUSY : ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (cycle == CYC_X3) begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Read data is on the bus during cycle 6 and sampled at its closing edge.
                    if (kind_q == KIND_IO && cycle == CYC_IO) begin
                        if (is_read_op(opc_q)) begin
                            rsp_rdata_q <= data;
                        end else if (opc_q != OP_WRM) begin
                            rsp_rdata_q <= 4'h0;
                        end
                    end
                    if (cycle == CYC_X3) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= accept ? ST_BUSY : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        drv_en  = 1'b0;
        drv_val = 4'h0;
        cmd_n_d = 1'b1;
        if (state_q == ST_BUSY) begin
            if (kind_q == KIND_SRC) begin
                if (cycle == CYC_SRC_HI) begin
                    cmd_n_d = 1'b0;
                    drv_en  = 1'b1;
                    drv_val = {addr_q[7:6], addr_q[5:4]};
                end else if (cycle == CYC_SRC_LO) begin
                    drv_en  = 1'b1;
                    drv_val = addr_q[3:0];
                end
            end else begin
                // cmd_n stays high in cycle 6 so responders never mistake this for an SRC.
                if (cycle == CYC_OPC) begin
                    cmd_n_d = 1'b0;
                    drv_en  = 1'b1;
                    drv_val = opc_q;
                end else if (cycle == CYC_IO && opc_q == OP_WRM) begin
                    drv_en  = 1'b1;
                    drv_val = wdata_q;
                end
            end
        end
    end

    assign data      = drv_en ? drv_val : 4'bzzzz;
    assign cmd_n     = cmd_n_d;
    assign sync      = (cycle == CYC_X3);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
